// File: rtl/gpio_pkg.sv
// Shared GPIO definitions: register offsets, register selector enum and CR layout.
package gpio_pkg;

    localparam int unsigned BUS_AW = 12;
    localparam int unsigned BUS_DW = 32;

    localparam logic [BUS_AW-1:0] GPIO_CR_OFFSET   = 12'h000;
    localparam logic [BUS_AW-1:0] GPIO_SR_OFFSET   = 12'h004;
    localparam logic [BUS_AW-1:0] GPIO_ODR_OFFSET  = 12'h008;
    localparam logic [BUS_AW-1:0] GPIO_IDR_OFFSET  = 12'h00C;
    localparam logic [BUS_AW-1:0] GPIO_IER_OFFSET  = 12'h010;
    localparam logic [BUS_AW-1:0] GPIO_ISR_OFFSET  = 12'h014;
    localparam logic [BUS_AW-1:0] GPIO_RIER_OFFSET = 12'h018;
    localparam logic [BUS_AW-1:0] GPIO_FIER_OFFSET = 12'h01C;
    localparam logic [BUS_AW-1:0] GPIO_DIR_OFFSET  = 12'h020;
    localparam logic [BUS_AW-1:0] GPIO_OSET_OFFSET = 12'h024;
    localparam logic [BUS_AW-1:0] GPIO_OCLR_OFFSET = 12'h028;
    localparam logic [BUS_AW-1:0] GPIO_DBCR_OFFSET = 12'h02C;

    typedef enum logic [3:0] {
        GPIO_CR,
        GPIO_SR,
        GPIO_ODR,
        GPIO_IDR,
        GPIO_IER,
        GPIO_ISR,
        GPIO_RIER,
        GPIO_FIER,
        GPIO_DIR,
        GPIO_OSET,
        GPIO_OCLR,
        GPIO_DBCR,
        GPIO_NONE
    } gpio_reg_t;

    typedef struct packed {
        logic [31:1] res;
        logic        gie;
    } gpio_cr_t;

    function automatic gpio_reg_t gpio_decode(input logic [BUS_AW-1:0] addr);
        gpio_reg_t r;
        case (addr)
            GPIO_CR_OFFSET:   r = GPIO_CR;
            GPIO_SR_OFFSET:   r = GPIO_SR;
            GPIO_ODR_OFFSET:  r = GPIO_ODR;
            GPIO_IDR_OFFSET:  r = GPIO_IDR;
            GPIO_IER_OFFSET:  r = GPIO_IER;
            GPIO_ISR_OFFSET:  r = GPIO_ISR;
            GPIO_RIER_OFFSET: r = GPIO_RIER;
            GPIO_FIER_OFFSET: r = GPIO_FIER;
            GPIO_DIR_OFFSET:  r = GPIO_DIR;
            GPIO_OSET_OFFSET: r = GPIO_OSET;
            GPIO_OCLR_OFFSET: r = GPIO_OCLR;
            GPIO_DBCR_OFFSET: r = GPIO_DBCR;
            default:          r = GPIO_NONE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gpio_input_stage.sv
// Per-pin input synchroniser, optionally followed by a debounce filter (GPIO_DEBOUNCE_EN).
module gpio_input_stage #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2
`ifdef GPIO_DEBOUNCE_EN
    ,
    parameter int unsigned DB_CNT_W    = 8
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WIDTH-1:0]    pin_in,
`ifdef GPIO_DEBOUNCE_EN
    input  logic [DB_CNT_W-1:0] db_limit,
`endif
    output logic [WIDTH-1:0]    din
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] synced;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= pin_in;
            for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
    logic [WIDTH-1:0]    filt_q;
    logic [DB_CNT_W-1:0] cnt_q [WIDTH];

    // A new level is accepted only after db_limit+1 consecutive cycles of disagreement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= '0;
            for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (synced[i] == filt_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == db_limit) begin
                    filt_q[i] <= synced[i];
                    cnt_q[i]  <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + DB_CNT_W'(1);
                end
            end
        end
    end

    assign din = filt_q;
`else
    assign din = synced;
`endif

endmodule

// File: rtl/gpio_ctrl.sv
// Parametrised GPIO peripheral: register decode, set/clear outputs, edge capture, irq.
// Optional debounce filter enabled by defining GPIO_DEBOUNCE_EN.
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bus_req,
    output logic              bus_gnt,
    input  logic              bus_we,
    input  logic [11:0]       bus_addr,
    input  logic [31:0]       bus_wdata,
    output logic              bus_rvalid,
    output logic [31:0]       bus_rdata,
    input  logic [WIDTH-1:0]  gpio_in,
    output logic [WIDTH-1:0]  gpio_out,
    output logic [WIDTH-1:0]  gpio_oe,
    output logic              irq
);

    gpio_reg_t        sel;
    logic             wr_en;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] ev;
    logic [WIDTH-1:0] w1c_mask;
    logic [WIDTH-1:0] odr_q, ier_q, isr_q, rier_q, fier_q, dir_q;
    logic             gie_q;
    logic [DB_CNT_W-1:0] dbcr_q;
    logic [31:0]      rd_data;
    gpio_cr_t         cr_rd;
    gpio_cr_t         cr_wr;
    logic             unused_wdata;

    assign bus_gnt      = bus_req;
    assign sel          = gpio_decode(bus_addr);
    assign wr_en        = bus_req & bus_we;
    assign wdata        = bus_wdata[WIDTH-1:0];
    assign cr_wr        = gpio_cr_t'(bus_wdata);
    assign unused_wdata = ^bus_wdata;

    gpio_input_stage #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
`ifdef GPIO_DEBOUNCE_EN
        ,
        .DB_CNT_W    (DB_CNT_W)
`endif
    ) u_input_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .pin_in   (gpio_in),
`ifdef GPIO_DEBOUNCE_EN
        .db_limit (dbcr_q),
`endif
        .din      (din)
    );

    // Edge detection; a capture in the same cycle as a W1C keeps the bit set.
    assign ev       = ((din & ~prev_q) & rier_q) | ((~din & prev_q) & fier_q);
    assign w1c_mask = (wr_en && sel == GPIO_ISR) ? wdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gie_q  <= 1'b0;
            odr_q  <= '0;
            ier_q  <= '0;
            isr_q  <= '0;
            rier_q <= '0;
            fier_q <= '0;
            dir_q  <= '0;
            prev_q <= '0;
            irq    <= 1'b0;
        end else begin
            prev_q <= din;
            isr_q  <= (isr_q & ~w1c_mask) | ev;
            irq    <= gie_q & (|(isr_q & ier_q));
            if (wr_en) begin
                case (sel)
                    GPIO_CR:   gie_q  <= cr_wr.gie;
                    GPIO_ODR:  odr_q  <= wdata;
                    GPIO_IER:  ier_q  <= wdata;
                    GPIO_RIER: rier_q <= wdata;
                    GPIO_FIER: fier_q <= wdata;
                    GPIO_DIR:  dir_q  <= wdata;
                    GPIO_OSET: odr_q  <= odr_q | wdata;
                    GPIO_OCLR: odr_q  <= odr_q & ~wdata;
                    default:   ;
                endcase
            end
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbcr_q <= '0;
        end else if (wr_en && sel == GPIO_DBCR) begin
            dbcr_q <= DB_CNT_W'(bus_wdata);
        end
    end
`else
    assign dbcr_q = '0;
`endif

    // Read mux; unmapped and write-only offsets return 0.
    always_comb begin
        rd_data = '0;
        cr_rd   = '0;
        cr_rd.gie = gie_q;
        case (sel)
            GPIO_CR:   rd_data = cr_rd;
            GPIO_SR:   rd_data = 32'(|(isr_q & ier_q));
            GPIO_ODR:  rd_data = 32'(odr_q);
            GPIO_IDR:  rd_data = 32'(din);
            GPIO_IER:  rd_data = 32'(ier_q);
            GPIO_ISR:  rd_data = 32'(isr_q);
            GPIO_RIER: rd_data = 32'(rier_q);
            GPIO_FIER: rd_data = 32'(fier_q);
            GPIO_DIR:  rd_data = 32'(dir_q);
            GPIO_DBCR: rd_data = 32'(dbcr_q);
            default:   rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_rvalid <= 1'b0;
            bus_rdata  <= '0;
        end else begin
            bus_rvalid <= bus_req;
            bus_rdata  <= (bus_req && !bus_we) ? rd_data : '0;
        end
    end

    assign gpio_out = odr_q;
    assign gpio_oe  = dir_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed self-checking bench for gpio_ctrl (32-pin and 8-pin instances share the bus).
module tb_gpio_ctrl;

`ifdef GPIO_DEBOUNCE_EN
    localparam int unsigned DB_LAT = 1;
`else
    localparam int unsigned DB_LAT = 0;
`endif
    localparam int unsigned LAT = 2 + DB_LAT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bus_req, bus_we;
    logic [11:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_gnt, bus_rvalid, irq;
    logic [31:0] bus_rdata;
    logic [31:0] gpio_in, gpio_out, gpio_oe;
    logic        gnt8, rvalid8, irq8;
    logic [31:0] rdata8;
    logic [7:0]  gpio_out8, gpio_oe8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gpio_ctrl dut (
        .clk(clk), .rst_n(rst_n), .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata), .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe),
        .irq(irq)
    );

    gpio_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .bus_req(bus_req), .bus_gnt(gnt8), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rvalid(rvalid8),
        .bus_rdata(rdata8), .gpio_in(gpio_in[7:0]), .gpio_out(gpio_out8), .gpio_oe(gpio_oe8),
        .irq(irq8)
    );

    task automatic bus(input logic w, input logic [11:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic [31:0] rd8);
        @(negedge clk);
        bus_req = 1'b1; bus_we = w; bus_addr = a; bus_wdata = d;
        @(negedge clk);
        rd = bus_rdata; rd8 = rdata8;
        checks++;
        if (bus_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL rvalid addr=%h got=%b exp=1", a, bus_rvalid);
        end
        bus_req = 1'b0; bus_we = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        logic [31:0] r, r8;
        bus(1'b1, a, d, r, r8);
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] r, output logic [31:0] r8);
        bus(1'b0, a, 32'h0, r, r8);
    endtask

    task automatic test_reset;
        logic [31:0] r, r8;
        rst_n = 1'b0; bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
        gpio_in = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (irq !== 1'b0 || gpio_oe !== 32'h0 || gpio_out !== 32'h0 || bus_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs irq=%b oe=%h out=%h rvalid=%b exp all 0",
                     irq, gpio_oe, gpio_out, bus_rvalid);
        end
        rst_n = 1'b1;
        @(negedge clk);
        bus_req = 1'b1;
        #1;
        checks++;
        if (bus_gnt !== 1'b1) begin
            errors++;
            $display("FAIL gnt got=%b exp=1", bus_gnt);
        end
        bus_req = 1'b0;
        for (int a = 0; a <= 'h2C; a += 4) begin
            rd(12'(a), r, r8);
            checks++;
            if (r !== 32'h0) begin
                errors++;
                $display("FAIL reset_read addr=%h got=%h exp=0", a, r);
            end
        end
        rd(12'h03C, r, r8);
        checks++;
        if (r !== 32'h0) begin
            errors++;
            $display("FAIL unmapped_read got=%h exp=0", r);
        end
    endtask

    task automatic test_outputs;
        logic [31:0] r, r8;
        bus(1'b1, 12'h008, 32'h0000_00F0, r, r8);
        checks++;
        if (r !== 32'h0) begin
            errors++;
            $display("FAIL write_resp_rdata got=%h exp=0", r);
        end
        wr(12'h024, 32'h0000_000F);
        wr(12'h028, 32'h0000_0030);
        rd(12'h008, r, r8);
        checks++;
        if (r !== 32'h0000_00CF) begin
            errors++;
            $display("FAIL odr_setclr got=%h exp=000000cf", r);
        end
        checks++;
        if (gpio_out !== 32'h0000_00CF) begin
            errors++;
            $display("FAIL gpio_out got=%h exp=000000cf", gpio_out);
        end
        rd(12'h024, r, r8);
        checks++;
        if (r !== 32'h0) begin
            errors++;
            $display("FAIL oset_reads0 got=%h exp=0", r);
        end
        wr(12'h020, 32'h0000_00FF);
        checks++;
        if (gpio_oe !== 32'h0000_00FF) begin
            errors++;
            $display("FAIL gpio_oe got=%h exp=000000ff", gpio_oe);
        end
    endtask

    task automatic test_rise_irq;
        logic [31:0] r, r8;
        wr(12'h018, 32'h8);
        wr(12'h010, 32'h8);
        wr(12'h000, 32'h1);
        @(negedge clk);
        gpio_in[3] = 1'b1;
        repeat (LAT + 1) @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_early got=%b exp=0", irq);
        end
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_rise got=%b exp=1", irq);
        end
        rd(12'h014, r, r8);
        checks++;
        if (r !== 32'h8) begin
            errors++;
            $display("FAIL isr_rise got=%h exp=8", r);
        end
        rd(12'h004, r, r8);
        checks++;
        if (r !== 32'h1) begin
            errors++;
            $display("FAIL sr got=%h exp=1", r);
        end
        rd(12'h00C, r, r8);
        checks++;
        if (r !== 32'h8) begin
            errors++;
            $display("FAIL idr_pin3 got=%h exp=8", r);
        end
        wr(12'h014, 32'h8);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_hold_after_w1c got=%b exp=1", irq);
        end
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_clear got=%b exp=0", irq);
        end
        rd(12'h014, r, r8);
        checks++;
        if (r !== 32'h0) begin
            errors++;
            $display("FAIL isr_cleared got=%h exp=0", r);
        end
    endtask

    task automatic test_fall_w1c;
        logic [31:0] r, r8;
        wr(12'h01C, 32'h20);
        @(negedge clk);
        gpio_in[5] = 1'b1;
        repeat (LAT + 4) @(negedge clk);
        rd(12'h014, r, r8);
        checks++;
        if (r !== 32'h0) begin
            errors++;
            $display("FAIL isr_no_rise_capture got=%h exp=0", r);
        end
        @(negedge clk);
        gpio_in[5] = 1'b0;
        repeat (LAT) @(negedge clk);
        // W1C accepted on the same edge that captures the falling edge
        bus_req = 1'b1; bus_we = 1'b1; bus_addr = 12'h014; bus_wdata = 32'h20;
        @(negedge clk);
        bus_req = 1'b0; bus_we = 1'b0;
        rd(12'h014, r, r8);
        checks++;
        if (r !== 32'h20) begin
            errors++;
            $display("FAIL isr_set_wins got=%h exp=20", r);
        end
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_ier_masked got=%b exp=0", irq);
        end
        wr(12'h014, 32'hFFFF_FFFF);
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        bus_req = 1'b1; bus_we = 1'b1; bus_addr = 12'h008; bus_wdata = 32'h12;
        @(negedge clk);
        checks++;
        if (bus_rvalid !== 1'b1 || bus_rdata !== 32'h0) begin
            errors++;
            $display("FAIL b2b_write rvalid=%b rdata=%h exp 1/0", bus_rvalid, bus_rdata);
        end
        bus_we = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_rvalid !== 1'b1 || bus_rdata !== 32'h12) begin
            errors++;
            $display("FAIL b2b_read rvalid=%b rdata=%h exp 1/12", bus_rvalid, bus_rdata);
        end
        bus_req = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle rvalid=%b exp=0", bus_rvalid);
        end
    endtask

    task automatic test_width8;
        logic [31:0] r, r8;
        wr(12'h008, 32'hFFFF_FFFF);
        rd(12'h008, r, r8);
        checks++;
        if (r8 !== 32'h0000_00FF || r !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL odr_width r8=%h r=%h exp 000000ff/ffffffff", r8, r);
        end
        checks++;
        if (gpio_out8 !== 8'hFF) begin
            errors++;
            $display("FAIL gpio_out8 got=%h exp=ff", gpio_out8);
        end
        gpio_in = 32'h80;
        repeat (LAT + 4) @(negedge clk);
        wr(12'h00C, 32'hFFFF);
        rd(12'h00C, r, r8);
        checks++;
        if (r8 !== 32'h80 || r !== 32'h80) begin
            errors++;
            $display("FAIL idr_pin7 r8=%h r=%h exp 80/80", r8, r);
        end
        wr(12'h03C, 32'hFFFF_FFFF);
        rd(12'h03C, r, r8);
        checks++;
        if (r !== 32'h0) begin
            errors++;
            $display("FAIL unmapped_write got=%h exp=0", r);
        end
        wr(12'h02C, 32'h5);
        rd(12'h02C, r, r8);
        checks++;
`ifdef GPIO_DEBOUNCE_EN
        if (r !== 32'h5) begin
            errors++;
            $display("FAIL dbcr_rw got=%h exp=5", r);
        end
`else
        if (r !== 32'h0) begin
            errors++;
            $display("FAIL dbcr_absent got=%h exp=0", r);
        end
`endif
    endtask

`ifdef GPIO_DEBOUNCE_EN
    task automatic test_debounce;
        logic [31:0] r, r8;
        gpio_in = '0;
        repeat (12) @(negedge clk);
        wr(12'h02C, 32'h3);
        wr(12'h014, 32'hFFFF_FFFF);
        wr(12'h018, 32'h1);
        wr(12'h010, 32'h1);
        wr(12'h000, 32'h1);
        @(negedge clk);
        gpio_in[0] = 1'b1;
        repeat (3) @(negedge clk);
        gpio_in[0] = 1'b0;
        repeat (10) @(negedge clk);
        rd(12'h00C, r, r8);
        checks++;
        if (r !== 32'h0) begin
            errors++;
            $display("FAIL db_glitch_idr got=%h exp=0", r);
        end
        rd(12'h014, r, r8);
        checks++;
        if (r !== 32'h0) begin
            errors++;
            $display("FAIL db_glitch_isr got=%h exp=0", r);
        end
        @(negedge clk);
        gpio_in[0] = 1'b1;
        repeat (7) @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL db_irq_early got=%b exp=0", irq);
        end
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL db_irq got=%b exp=1", irq);
        end
        rd(12'h00C, r, r8);
        checks++;
        if (r !== 32'h1) begin
            errors++;
            $display("FAIL db_idr got=%h exp=1", r);
        end
        gpio_in[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL db_reset_irq got=%b exp=0", irq);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rd(12'h00C, r, r8);
        checks++;
        if (r !== 32'h0) begin
            errors++;
            $display("FAIL db_reset_idr got=%h exp=0", r);
        end
        rd(12'h02C, r, r8);
        checks++;
        if (r !== 32'h0) begin
            errors++;
            $display("FAIL db_reset_dbcr got=%h exp=0", r);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_outputs();
        test_rise_irq();
        test_fall_w1c();
        test_back_to_back();
        test_width8();
`ifdef GPIO_DEBOUNCE_EN
        test_debounce();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
